// File: rtl/mips_pkg.sv
// Shared definitions for the serial subtract path: default width and the
// controller state encoding.
package mips_pkg;

   localparam int SUB_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/bit_serial_subtractor_if.sv
// Request/result bundle of the serial subtractor; master issues operands,
// slave (the subtractor) returns status and registered results.
interface bit_serial_subtractor_if #(parameter int WIDTH = mips_pkg::SUB_WIDTH);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             ovf;
   logic             zero;

   modport master (output start, a, b,
                   input  busy, done, diff, borrow, ovf, zero);
   modport slave  (input  start, a, b,
                   output busy, done, diff, borrow, ovf, zero);
endinterface

// File: rtl/HS_SSL.sv
// Half-subtractor cell: s = x - y (difference bit), B = borrow out.
module HS_SSL (
   input  logic x,
   input  logic y,
   output logic s,
   output logic B
);
   assign s = x ^ y;
   assign B = ~x & y;
endmodule

// File: rtl/full_sub_bit.sv
// One-bit full subtractor: x - y - bin, built from two half-subtractor cells.
module full_sub_bit (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);
   logic s1, b1, b2;

   HS_SSL u_hs0 (.x(x),  .y(y),   .s(s1), .B(b1));
   HS_SSL u_hs1 (.x(s1), .y(bin), .s(d),  .B(b2));

   assign bout = b1 | b2;
endmodule

// File: rtl/bit_serial_subtractor.sv
// LSB-first serial subtractor: one bit per clock through a single full-subtract
// slice, borrow carried in a flop, results registered on completion.
module bit_serial_subtractor
   import mips_pkg::*;
#(
   parameter int WIDTH = SUB_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   bit_serial_subtractor_if.slave  bus
);
   localparam int           CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, res_q, res_d;
   logic             bq_q, bq_d;
   logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d, ovf_q, ovf_d, zero_q, zero_d;

   logic             d_bit, bo_bit;
   logic [WIDTH-1:0] res_shift;

   full_sub_bit u_slice (
      .x   (sa_q[0]),
      .y   (sb_q[0]),
      .bin (bq_q),
      .d   (d_bit),
      .bout(bo_bit)
   );

   assign res_shift = {d_bit, res_q[WIDTH-1:1]};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      res_d    = res_q;
      bq_d     = bq_q;
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               sa_d    = bus.a;
               sb_d    = bus.b;
               a_msb_d = bus.a[WIDTH-1];
               b_msb_d = bus.b[WIDTH-1];
               bq_d    = 1'b0;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            res_d = res_shift;
            bq_d  = bo_bit;
            cnt_d = cnt_q + CW'(1);
            // Last bit: the slice output completes the result this very edge.
            if (cnt_q == LAST) begin
               diff_d   = res_shift;
               borrow_d = bo_bit;
               ovf_d    = (a_msb_q != b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
               zero_d   = (res_shift == '0);
               state_d  = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         sa_q     <= '0;
         sb_q     <= '0;
         res_q    <= '0;
         bq_q     <= 1'b0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         res_q    <= res_d;
         bq_q     <= bq_d;
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
      end
   end

   assign bus.busy   = (state_q == ST_SHIFT);
   assign bus.done   = (state_q == ST_DONE);
   assign bus.diff   = diff_q;
   assign bus.borrow = borrow_q;
   assign bus.ovf    = ovf_q;
   assign bus.zero   = zero_q;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Randomised and directed bench for bit_serial_subtractor (WIDTH=8) against an
// arithmetic reference model of a - b.
module tb_bit_serial_subtractor;
   localparam int W = 8;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   logic prev_done;
   logic [10:0] exp_cur;

   bit_serial_subtractor_if #(.WIDTH(W)) bus ();

   bit_serial_subtractor #(.WIDTH(W)) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, want, $time);
      end
   endtask

   // Reference: {diff, borrow, ovf, zero} from plain integer arithmetic.
   function automatic logic [10:0] model(input int a, input int b);
      int         sa, sb, sd;
      logic [7:0] d;
      logic       brw, ov, z;
      d   = 8'(a - b);
      brw = (a < b);
      sa  = (a > 127) ? a - 256 : a;
      sb  = (b > 127) ? b - 256 : b;
      sd  = sa - sb;
      ov  = (sd > 127) || (sd < -128);
      z   = (d == 8'd0);
      return {d, brw, ov, z};
   endfunction

   function automatic logic [10:0] outs();
      return {bus.diff, bus.borrow, bus.ovf, bus.zero};
   endfunction

   always @(negedge clk) begin
      if (bus.busy || bus.done)
         check_eq("busy_done_overlap", 32'(bus.busy && bus.done), 32'd0);
      if (bus.done)
         check_eq("done_width", 32'(prev_done), 32'd0);
      prev_done = bus.done;
   end

   // Entered at the first negedge after the accepting edge; returns at the
   // negedge of the done cycle after checking the result.
   task automatic wait_result(input int a, input int b, input bit inject, input string tag);
      int lat, busy_n;
      lat    = 1;
      busy_n = 0;
      while (!bus.done && lat < 40) begin
         if (bus.busy) busy_n++;
         check_eq({tag, "_hold"}, 32'(outs()), 32'(exp_cur));
         if (inject && lat == 3) begin
            bus.start = 1'b1;
            bus.a     = 8'd9;
            bus.b     = 8'd9;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      bus.start = 1'b0;
      check_eq({tag, "_latency"}, 32'(lat), 32'd9);
      check_eq({tag, "_busy_cycles"}, 32'(busy_n), 32'd8);
      exp_cur = model(a, b);
      check_eq({tag, "_result"}, 32'(outs()), 32'(exp_cur));
      $display("op %s: a=%02h b=%02h diff=%02h borrow=%0b ovf=%0b zero=%0b latency=%0d",
               tag, a[7:0], b[7:0], bus.diff, bus.borrow, bus.ovf, bus.zero, lat);
   endtask

   task automatic launch(input int a, input int b);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 8'(a);
      bus.b     = 8'(b);
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = 8'($urandom);
      bus.b     = 8'($urandom);
   endtask

   task automatic run_op(input int a, input int b, input string tag);
      launch(a, b);
      wait_result(a, b, 1'b0, tag);
      @(negedge clk);
      check_eq({tag, "_after"}, 32'(outs()), 32'(exp_cur));
      check_eq({tag, "_done_low"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      prev_done = 1'b0;
      exp_cur   = '0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(negedge clk);
      check_eq("reset_outs", 32'(outs()), 32'd0);
      check_eq("reset_busy", 32'(bus.busy), 32'd0);
      check_eq("reset_done", 32'(bus.done), 32'd0);
      rst_n = 1'b1;

      run_op(8'h5A, 8'h3C, "t1");
      run_op(8'h10, 8'h20, "t2");
      run_op(8'h80, 8'h01, "t3a");
      run_op(8'h7F, 8'hFF, "t3b");
      run_op(8'hA5, 8'hA5, "t4a");
      run_op(8'h00, 8'h01, "t4b");

      // Ignored start during busy, then start held in the done cycle.
      launch(3, 1);
      wait_result(3, 1, 1'b1, "t5a");
      bus.start = 1'b1;
      bus.a     = 8'h40;
      bus.b     = 8'h11;
      @(negedge clk);
      bus.start = 1'b0;
      wait_result(8'h40, 8'h11, 1'b0, "t5b");
      @(negedge clk);
      check_eq("t5b_after", 32'(outs()), 32'(exp_cur));

      // Asynchronous abort mid-shift.
      launch(8'h77, 8'h12);
      repeat (3) @(negedge clk);
      check_eq("t6_busy_before", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("t6_abort_outs", 32'(outs()), 32'd0);
      check_eq("t6_abort_busy", 32'(bus.busy), 32'd0);
      check_eq("t6_abort_done", 32'(bus.done), 32'd0);
      $display("op t6: reset asserted mid-shift");
      exp_cur = '0;
      @(negedge clk);
      check_eq("t6_no_done", 32'(bus.done), 32'd0);
      rst_n = 1'b1;
      run_op(8'h05, 8'h03, "t6b");

      for (int i = 0; i < 200; i++) begin
         int ra, rb;
         ra = int'($urandom_range(255, 0));
         rb = int'($urandom_range(255, 0));
         if (i % 17 == 0) rb = ra;
         run_op(ra, rb, "rnd");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
